// File: rtl/button_events_pkg.sv
// Shared types and default timing for button_events.
// Holds the FSM state encoding, the 100 MHz default periods, and a helper
// that sizes the shared cycle counter.
package button_events_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESSED  = 3'd1,
        ST_HELD     = 3'd2,
        ST_WAIT_DBL = 3'd3,
        ST_PRESSED2 = 3'd4
    } state_t;

    // Default periods at a 100 MHz clock
    localparam int unsigned LONG_CYCLES_100MHZ = 100_000_000; // 1.0 s hold
    localparam int unsigned DBL_CYCLES_100MHZ  = 25_000_000;  // 250 ms gap
    localparam int unsigned RPT_CYCLES_100MHZ  = 10_000_000;  // 100 ms repeat

    // Largest of three periods; sizes the one counter they all share
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/button_events.sv
// Button gesture decoder: turns a clean button level into press/release,
// click, double-click, long-press and auto-repeat pulses.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   debounced  clean synchronous button level, 1 = pressed
//   press      one-cycle pulse on each press
//   rel        one-cycle pulse on each release
//   click      one-cycle pulse for a single short click
//   dbl_click  one-cycle pulse for a double click
//   long_press one-cycle pulse when a hold reaches LONG_CYCLES
//   rpt        one-cycle auto-repeat pulse while held after a long press
//   busy       level, high whenever the FSM is not idle
module button_events
    import button_events_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_100MHZ,
    parameter int unsigned DBL_CYCLES  = DBL_CYCLES_100MHZ,
    parameter int unsigned RPT_CYCLES  = RPT_CYCLES_100MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic debounced,
    output logic press,
    output logic rel,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic rpt,
    output logic busy
);

    localparam int unsigned MAX_CYCLES = max3(LONG_CYCLES, DBL_CYCLES, RPT_CYCLES);
    // At least one bit so that all-ones parameter sets still elaborate
    localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Gesture FSM; level changes are tested before counter expiry so they win ties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            press      <= 1'b0;
            rel        <= 1'b0;
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
            rpt        <= 1'b0;
        end else begin
            press      <= 1'b0;
            rel        <= 1'b0;
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
            rpt        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (debounced) begin
                        state <= ST_PRESSED;
                        press <= 1'b1;
                    end
                end

                ST_PRESSED: begin
                    if (!debounced) begin
                        state <= ST_WAIT_DBL;
                        rel   <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= ST_HELD;
                        long_press <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_HELD: begin
                    if (!debounced) begin
                        state <= ST_IDLE;
                        rel   <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == RPT_LAST) begin
                        rpt <= 1'b1;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_DBL: begin
                    if (debounced) begin
                        state     <= ST_PRESSED2;
                        press     <= 1'b1;
                        dbl_click <= 1'b1;
                        cnt       <= '0;
                    end else if (cnt == DBL_LAST) begin
                        state <= ST_IDLE;
                        click <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_PRESSED2: begin
                    // Second press of a double click: only waits for release
                    cnt <= '0;
                    if (!debounced) begin
                        state <= ST_IDLE;
                        rel   <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 100000000, meaning press duration (clocks) that qualifies as a long press.
REQ-002 SHALL have parameter DBL_CYCLES, default 25000000, meaning maximum release gap (clocks) before a second press counts as a double click.
REQ-003 SHALL have parameter RPT_CYCLES, default 10000000, meaning auto-repeat period (clocks) while held after a long press.
REQ-004 SHALL have ports with one clock; reset is asynchronous and active-high:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- debounced  input  1  clean, synchronous button level; 1 = pressed
- press  output  1  one-cycle pulse on each press
- rel  output  1  one-cycle pulse on each release
- click  output  1  one-cycle pulse for a single short click
- dbl_click  output  1  one-cycle pulse for a double click
- long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES
- rpt  output  1  one-cycle auto-repeat pulse while held
- busy  output  1  level; high whenever state is not IDLE

Function
REQ-005 SHALL implement the FSM states IDLE, PRESSED, HELD, WAIT_DBL and PRESSED2, with one shared cycle counter that clears on every state transition.
REQ-006 SHALL register all outputs: each pulse is high for exactly one clock, in the cycle after the edge that sampled the qualifying condition.
REQ-007 In IDLE, debounced=1 -> PRESSED, and press pulses.
REQ-008 In PRESSED, debounced=0 -> WAIT_DBL, and rel pulses; when counter==LONG_CYCLES-1 with debounced=1 -> HELD, and long_press pulses. long_press rises exactly LONG_CYCLES clocks after press rises.
REQ-009 In HELD, rpt SHALL pulse every RPT_CYCLES clocks: the first rpt comes RPT_CYCLES clocks after long_press, and the counter wraps to 0 on each rpt. debounced=0 -> IDLE, with a rel pulse and no click.
REQ-010 In WAIT_DBL, debounced=1 -> PRESSED2, with press and dbl_click pulsing in the same cycle; when counter==DBL_CYCLES-1 with debounced=0 -> IDLE, and click pulses DBL_CYCLES clocks after rel rises.
REQ-011 In PRESSED2, there is no long/repeat detection; debounced=0 -> IDLE, and rel pulses.
REQ-012 On a simultaneous level change and counter expiry, the level change SHALL win:
- release at LONG expiry gives a short press;
- press at DBL expiry gives a double click.
REQ-013 Counter width SHALL be clog2 of the largest of the three parameters, and the counter SHALL never exceed that parameter minus 1.
REQ-014 At most one of click, dbl_click, long_press SHALL assert per gesture; press and rel SHALL strictly alternate.
REQ-015 Parameters of 1 SHALL be legal: expiry occurs on the first counted cycle.
REQ-016 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-017 On reset=1, the block SHALL immediately force state to IDLE, the counter to 0, and all pulse outputs to 0; busy therefore reads 0.
REQ-018 Reset mid-gesture SHALL drop the gesture silently, with no trailing rel/click. After release, if debounced=1 is already present, press SHALL pulse on the first clock edge.

Structure
REQ-019 A shared package SHALL hold the state encoding type and the default timing constants (LONG/DBL/RPT at 100 MHz).
REQ-020 SHALL contain no sub-module: three different periods share one internal counter, so the fixed-period timer is not instantiated.
REQ-021 Intended placement is directly after a debouncer instance, whose output drives debounced.

Verification (LONG_CYCLES=20, DBL_CYCLES=8, RPT_CYCLES=5)
REQ-022 Single click: hold 1 for 6 clocks, then 0 for 12 -> press once, rel once, click 8 clocks after rel; no dbl_click or long_press.
REQ-023 Double click: 1 for 4, 0 for 3, 1 for 4, 0 -> press, rel, press together with dbl_click, rel; no click.
REQ-024 Long hold: 1 for 33 clocks, then 0 -> long_press 20 clocks after press, rpt at +25 and +30, rel on release; no click.
REQ-025 Boundary:
- release on the exact cycle counter==19 -> WAIT_DBL, no long_press;
- re-press on the cycle counter==7 in WAIT_DBL -> dbl_click, no click.
REQ-026 Reset asserted in HELD and in WAIT_DBL -> all outputs 0 at once; no click/rel afterwards; busy=0 until next press.
